register_pipe_elastic: RTL and testbench



---
 rtl/register_pipe_elastic.sv | 98 +++++++++
 tb/tb_register_pipe_elastic.sv | 134 +++++++++++++
 2 files changed

// File: rtl/register_pipe_elastic.sv
// Elastic pipeline register: DEPTH valid-tagged stages with a valid/ready
// handshake at both ends, bubble collapse, occupancy count and synchronous flush.
module register_pipe_elastic #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] rdy;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             in_xfer, out_xfer;

   // A stage may load when it is empty or the stage after it can move on.
   always_comb begin
      rdy = '0;
      rdy[DEPTH-1] = !valid_q[DEPTH-1] | out_ready;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         rdy[DEPTH-1-k] = !valid_q[DEPTH-1-k] | rdy[DEPTH-k];
      end
   end

   assign in_ready  = rdy[0] & !flush & !reset;
   assign in_xfer   = in_valid & in_ready;
   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
   assign out_xfer  = out_valid & out_ready;
   assign occupancy = occ_q;

   always_comb begin
      valid_d = valid_q;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         data_d[k] = data_q[k];
      end

      if (rdy[0]) begin
         valid_d[0] = in_xfer;
         if (in_xfer) begin
            data_d[0] = in_data;
         end
      end

      for (int unsigned k = 1; k < DEPTH; k++) begin
         if (rdy[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end

      if (flush) begin
         valid_d = '0;
      end
   end

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (in_xfer && !out_xfer) begin
         occ_d = occ_q + CNT_W'(1);
      end else if (!in_xfer && out_xfer) begin
         occ_d = occ_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         occ_q   <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

endmodule

// File: tb/tb_register_pipe_elastic.sv
// Bench for register_pipe_elastic: directed scenarios plus random traffic
// checked against a queue-of-words model with per-word stage positions.
module tb_register_pipe_elastic;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] in_data, out_data;
   logic [CNT_W-1:0] occupancy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Model: oldest word first, each with the stage index it occupies.
   logic [WIDTH-1:0] mdata [$];
   int               mpos  [$];

   always #5 clk = ~clk;

   register_pipe_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input logic rst, input logic fl, input logic iv,
                       input logic [WIDTH-1:0] id, input logic ordy);
      logic exp_ir, exp_ov, in_x, out_x;
      int   n;
      reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      n      = mdata.size();
      exp_ov = (n > 0) && (mpos[0] == int'(DEPTH) - 1);
      exp_ir = !rst && !fl && ((n < int'(DEPTH)) || ordy);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      check("occupancy", 32'(occupancy), 32'(n));
      if (exp_ov) check("out_data", 32'(out_data), 32'(mdata[0]));
      @(posedge clk);
      if (rst) begin
         mdata.delete();
         mpos.delete();
      end else begin
         out_x = exp_ov && ordy;
         in_x  = exp_ir && iv;
         // A word moves if a free stage lies ahead of it, or the whole run drains by one.
         for (int k = 0; k < n; k++) begin
            if ((int'(DEPTH) - 1 - mpos[k] > k) || out_x) mpos[k]++;
         end
         if (out_x) begin
            void'(mdata.pop_front());
            void'(mpos.pop_front());
         end
         if (fl) begin
            mdata.delete();
            mpos.delete();
         end else if (in_x) begin
            mdata.push_back(id);
            mpos.push_back(0);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      step(1, 0, 0, 8'h00, 0);
      check("rst_out_data", 32'(out_data), 32'd0);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hA0 + 8'(i), 0);
      step(1, 0, 0, 8'h00, 0);
      check("rst_mid_out_data", 32'(out_data), 32'd0);
      step(0, 0, 0, 8'h00, 1);

      // Streaming with out_ready held high
      for (int i = 1; i <= 16; i++) step(0, 0, 1, 8'(i), 1);
      for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 8'h00, 1);

      // Fill under stall, then release
      for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h30 + 8'(i), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h40 + 8'(i), 1);
      for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 8'h00, 1);

      // Bubble collapse: two words separated by idle cycles under stall
      step(0, 0, 1, 8'hAA, 0);
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 1, 8'hBB, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);

      // Flush while full with the consumer taking the output word
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h50 + 8'(i), 0);
      step(0, 1, 1, 8'h5F, 1);
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 1, 8'h60, 1);
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 8'h00, 1);

      // Random traffic with rare flush and reset
      for (int i = 0; i < 10000; i++) begin
         step(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)),
              8'($urandom),
              1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
